// File: rtl/pr_avalon_mem_responder_if.sv
// Avalon-MM local-memory channel crossing the PR boundary.
// The AFU side uses the master modport. The platform-side responder uses the slave modport.
interface pr_avalon_mem_responder_if #(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 576,
    parameter int BURSTCOUNT_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0]       address;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic                        read;
    logic                        write;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [DATA_WIDTH/8-1:0]     byteenable;
    logic                        waitrequest;
    logic [DATA_WIDTH-1:0]       readdata;
    logic                        readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/pr_avalon_mem_responder.sv
// Platform-side terminator of the PR-boundary Avalon-MM local-memory channel.
// It accepts AFU burst reads and writes and services them from an internal line-addressed RAM.
// It stands in for the memory controller when no EMIF is present.
module pr_avalon_mem_responder #(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 576,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter int READ_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    pr_avalon_mem_responder_if.slave  bus,
    input  logic                      stall,
    input  logic                      inject_ecc,
    output logic                      ecc_interrupt,
    output logic                      protocol_err
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE = BURSTCOUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_ISSUE = 2'd2
    } state_t;

    state_t                      state, state_next;
    logic [MEM_ADDR_WIDTH-1:0]   wr_addr, wr_addr_next;
    logic [BURSTCOUNT_WIDTH-1:0] wr_left, wr_left_next;
    logic [MEM_ADDR_WIDTH-1:0]   rd_addr, rd_addr_next;
    logic [BURSTCOUNT_WIDTH-1:0] rd_left, rd_left_next;
    logic                        ecc_arm;

    logic                        waitrequest;
    logic                        accept;
    logic [MEM_ADDR_WIDTH-1:0]   addr_idx;
    logic [BURSTCOUNT_WIDTH-1:0] bc_eff;
    logic                        mem_we;
    logic [MEM_ADDR_WIDTH-1:0]   mem_widx;
    logic                        issue;
    logic                        err_set;

    logic [DATA_WIDTH-1:0]       mem [MEM_DEPTH];

    logic [READ_LATENCY-1:0]     vld_p;
    logic [READ_LATENCY-1:0]     ecc_p;
    logic [DATA_WIDTH-1:0]       dat_p [READ_LATENCY];

    // Upper address bits alias onto the RAM and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    // While the read burst is being issued, no new command can be taken.
    assign waitrequest     = reset | stall | (state == RD_ISSUE);
    assign bus.waitrequest = waitrequest;
    assign accept          = (bus.read | bus.write) & ~waitrequest;
    assign addr_idx        = bus.address[MEM_ADDR_WIDTH-1:0];

    // A zero burstcount is serviced as a single beat.
    assign bc_eff = (bus.burstcount == '0) ? BC_ONE : bus.burstcount;

    // Registered FSM state, burst counters, ECC arm and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_addr      <= '0;
            wr_left      <= '0;
            rd_addr      <= '0;
            rd_left      <= '0;
            ecc_arm      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state   <= state_next;
            wr_addr <= wr_addr_next;
            wr_left <= wr_left_next;
            rd_addr <= rd_addr_next;
            rd_left <= rd_left_next;
            // The issued beat consumes the arm. A new request in the same cycle re-arms it for the following beat.
            ecc_arm <= (ecc_arm & ~issue) | inject_ecc;
            if (err_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // Next-state logic, RAM write strobe, read-beat issue and protocol checks.
    always_comb begin
        state_next   = state;
        wr_addr_next = wr_addr;
        wr_left_next = wr_left;
        rd_addr_next = rd_addr;
        rd_left_next = rd_left;
        mem_we       = 1'b0;
        mem_widx     = addr_idx;
        issue        = 1'b0;
        err_set      = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.burstcount == '0) begin
                        err_set = 1'b1;
                    end
                    if (bus.write) begin
                        // Write takes priority when read and write collide.
                        mem_we   = 1'b1;
                        mem_widx = addr_idx;
                        if (bus.read) begin
                            err_set = 1'b1;
                        end
                        if (bc_eff > BC_ONE) begin
                            wr_addr_next = addr_idx + 1'b1;
                            wr_left_next = bc_eff - 1'b1;
                            state_next   = WR_BURST;
                        end
                    end else begin
                        rd_addr_next = addr_idx;
                        rd_left_next = bc_eff;
                        state_next   = RD_ISSUE;
                    end
                end
            end

            WR_BURST: begin
                if (bus.read) begin
                    err_set = 1'b1;
                end
                if (bus.write && !waitrequest) begin
                    mem_we       = 1'b1;
                    mem_widx     = wr_addr;
                    wr_addr_next = wr_addr + 1'b1;
                    wr_left_next = wr_left - 1'b1;
                    if (wr_left == BC_ONE) begin
                        state_next = IDLE;
                    end
                end
            end

            RD_ISSUE: begin
                // Issue does not pause for stall. It only blocks new commands.
                issue        = 1'b1;
                rd_addr_next = rd_addr + 1'b1;
                rd_left_next = rd_left - 1'b1;
                if (rd_left == BC_ONE) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // RAM write port with per-byte lane enables.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (bus.byteenable[b]) begin
                    mem[mem_widx][b*8 +: 8] <= bus.writedata[b*8 +: 8];
                end
            end
        end
    end

    // Stage p0 is the RAM read. Later stages delay the data to READ_LATENCY.
    always_ff @(posedge clk) begin
        dat_p[0] <= mem[rd_addr];
        for (int i = 1; i < READ_LATENCY; i++) begin
            dat_p[i] <= dat_p[i-1];
        end
    end

    // Valid and ECC tags travel alongside the data. Reset drops every beat in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            ecc_p <= '0;
        end else begin
            vld_p[0] <= issue;
            ecc_p[0] <= issue & ecc_arm;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                ecc_p[i] <= ecc_p[i-1];
            end
        end
    end

    // readdata is held at zero outside valid beats, so the unreset data pipe never leaks out.
    assign bus.readdatavalid = vld_p[READ_LATENCY-1];
    assign bus.readdata      = vld_p[READ_LATENCY-1] ? dat_p[READ_LATENCY-1] : '0;
    assign ecc_interrupt     = vld_p[READ_LATENCY-1] & ecc_p[READ_LATENCY-1];

endmodule

// File: tb/tb_pr_avalon_mem_responder.sv
// Bench for pr_avalon_mem_responder.
// Single-beat vectors come from a table. Burst, stall, ECC and reset cases are hand-written sequences.
// Expected read beats, with their arrival cycle, are queued and checked by a monitor.
module tb_pr_avalon_mem_responder;

    localparam int AW = 27;
    localparam int DW = 576;
    localparam int BW = 7;
    localparam int MW = 10;
    localparam int RL = 2;

    typedef struct {
        bit              is_rd;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
        logic [DW-1:0]   exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            ecc;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic inject_ecc;
    logic ecc_interrupt;
    logic protocol_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit ecc_pending = 0;

    exp_t          sb [$];
    logic [DW-1:0] model [2**MW];
    vec_t          vecs [10];

    pr_avalon_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW)) bus ();

    pr_avalon_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW),
        .MEM_ADDR_WIDTH(MW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .stall(stall),
        .inject_ecc(inject_ecc),
        .ecc_interrupt(ecc_interrupt),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every returned beat is matched against the queue head: data, ECC mark and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.readdatavalid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got readdatavalid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("rd_data", bus.readdata, e.data);
                check("rd_ecc", DW'(ecc_interrupt), DW'(e.ecc));
                check("rd_cycle", DW'(cyc), DW'(e.cyc));
            end
        end else begin
            check("ecc_idle", DW'(ecc_interrupt), '0);
        end
    end

    function automatic vec_t mk(bit is_rd, logic [AW-1:0] a, logic [DW-1:0] d,
                                logic [DW/8-1:0] be, logic [DW-1:0] exp);
        vec_t v;
        v.is_rd = is_rd; v.addr = a; v.data = d; v.be = be; v.exp = exp;
        return v;
    endfunction

    // Drives one write beat (optionally with read asserted too) and waits for acceptance.
    task automatic wr_beat(input logic [AW-1:0] addr, input int bc, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] be, input logic [MW-1:0] midx, input bit also_rd);
        bit acc = 0;
        bus.address = addr; bus.burstcount = BW'(bc); bus.writedata = d; bus.byteenable = be;
        bus.write = 1'b1; bus.read = also_rd;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk); acc = !bus.waitrequest;
            @(posedge clk); #1;
        end
        bus.write = 1'b0; bus.read = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL wr_accept_timeout: got no accept expected accept (addr %0h)", addr);
        end else begin
            for (int b = 0; b < DW/8; b++)
                if (be[b]) model[midx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Issues a read command and queues n_push expected beats timed from the accept cycle.
    task automatic rd_cmd(input logic [AW-1:0] addr, input int bc, input int n_push, input bit use_exp,
                          input logic [DW-1:0] exp, input int stall_cyc, output int t_acc);
        bit acc = 0;
        int a = 0;
        exp_t e;
        t_acc = -1;
        bus.address = addr; bus.burstcount = BW'(bc); bus.read = 1'b1; bus.write = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            stall = (t < stall_cyc);
            @(negedge clk); acc = !bus.waitrequest; a = cyc;
            if (acc) t_acc = t;
            @(posedge clk); #1;
        end
        bus.read = 1'b0; stall = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL rd_accept_timeout: got no accept expected accept (addr %0h)", addr);
        end else begin
            for (int k = 0; k < n_push; k++) begin
                e.data = use_exp ? exp : model[MW'(addr[MW-1:0] + MW'(k))];
                e.ecc  = (k == 0) && ecc_pending;
                e.cyc  = a + 1 + k + RL;
                sb.push_back(e);
            end
            if (n_push > 0) ecc_pending = 0;
        end
    endtask

    initial begin
        int t_acc, cnt;
        logic [7:0] d8;

        vecs[0] = mk(0, 27'h005, {72{8'hA5}}, '1, '0);
        vecs[1] = mk(1, 27'h005, '0, '0, {72{8'hA5}});
        vecs[2] = mk(0, 27'h007, {72{8'hFF}}, '1, '0);
        vecs[3] = mk(0, 27'h007, {72{8'h00}}, 72'h1, '0);
        vecs[4] = mk(1, 27'h007, '0, '0, {{71{8'hFF}}, 8'h00});
        vecs[5] = mk(0, 27'h400_000A, {36{16'hBEEF}}, '1, '0);
        vecs[6] = mk(1, 27'h00A, '0, '0, {36{16'hBEEF}});
        vecs[7] = mk(1, 27'h7FF_FC0A, '0, '0, {36{16'hBEEF}});
        vecs[8] = mk(0, 27'h00A, {72{8'h11}}, {{36{1'b1}}, {36{1'b0}}}, '0);
        vecs[9] = mk(1, 27'h00A, '0, '0, {{36{8'h11}}, {18{16'hBEEF}}});

        reset = 1'b1; stall = 1'b0; inject_ecc = 1'b0;
        bus.address = '0; bus.burstcount = '0; bus.read = 1'b0; bus.write = 1'b0;
        bus.writedata = '0; bus.byteenable = '0;
        for (int i = 0; i < 2**MW; i++) model[i] = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_waitrequest", DW'(bus.waitrequest), DW'(1));
        check("rst_readdatavalid", DW'(bus.readdatavalid), '0);
        check("rst_readdata", bus.readdata, '0);
        check("rst_protocol_err", DW'(protocol_err), '0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_waitrequest", DW'(bus.waitrequest), '0);
        @(posedge clk); #1;

        // Table-driven single beats: full write, byteenable merge, address aliasing
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_rd)
                rd_cmd(vecs[i].addr, 1, 1, 1, vecs[i].exp, 0, t_acc);
            else
                wr_beat(vecs[i].addr, 1, vecs[i].data, vecs[i].be, vecs[i].addr[MW-1:0], 0);
        end

        // Contiguous write burst of 8 at 0x100
        for (int k = 0; k < 8; k++) begin
            d8 = 8'h40 + 8'(k);
            wr_beat(27'h100, 8, {72{d8}}, '1, MW'(10'h100 + k), 0);
        end

        // Write burst with gaps that wraps the RAM, then read back
        for (int k = 0; k < 4; k++) begin
            if (k >= 2) begin @(posedge clk); #1; end
            d8 = 8'hC0 + 8'(k);
            wr_beat(27'h3FE, 4, {72{d8}}, '1, MW'(10'h3FE + k), 0);
        end
        check("wrap_model_0", model[0], {72{8'hC2}});
        rd_cmd(27'h3FE, 4, 4, 0, '0, 0, t_acc);
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.waitrequest) cnt++; else break;
        end
        check("rd4_waitrequest_cycles", DW'(cnt), DW'(4));
        @(posedge clk); #1;

        // Stall from idle: command held until stall drops
        rd_cmd(27'h100, 1, 1, 0, '0, 3, t_acc);
        check("idle_stall_accept_t", DW'(t_acc), DW'(3));
        repeat (4) @(posedge clk); #1;

        // Back-to-back reads, second under stall
        rd_cmd(27'h100, 3, 3, 0, '0, 0, t_acc);
        rd_cmd(27'h105, 2, 2, 0, '0, 2, t_acc);
        check("b2b_accept_t", DW'(t_acc), DW'(3));
        repeat (6) @(posedge clk); #1;
        check("b2b_protocol_err", DW'(protocol_err), '0);

        // ECC injection marks only the next beat
        inject_ecc = 1'b1; @(posedge clk); #1 inject_ecc = 1'b0;
        ecc_pending = 1;
        rd_cmd(27'h102, 2, 2, 0, '0, 0, t_acc);
        repeat (6) @(posedge clk); #1;

        // Read and write together: the write wins and the error is flagged
        wr_beat(27'h020, 1, {72{8'h5A}}, '1, 10'h020, 1);
        @(negedge clk);
        check("rdwr_protocol_err", DW'(protocol_err), DW'(1));
        @(posedge clk); #1;
        rd_cmd(27'h020, 1, 1, 1, {72{8'h5A}}, 0, t_acc);
        repeat (4) @(posedge clk); #1;

        // Reset after three issues of an 8-beat read: only beats 0 and 1 return
        rd_cmd(27'h100, 8, 2, 0, '0, 0, t_acc);
        repeat (3) @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_waitrequest_0", DW'(bus.waitrequest), DW'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_waitrequest_1", DW'(bus.waitrequest), DW'(1));
        check("midrst_readdata", bus.readdata, '0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_release_waitrequest", DW'(bus.waitrequest), '0);
        check("midrst_protocol_err", DW'(protocol_err), '0);
        repeat (8) @(posedge clk); #1;

        // burstcount 0 read returns one beat and flags the error
        rd_cmd(27'h005, 0, 1, 1, {72{8'hA5}}, 0, t_acc);
        @(negedge clk);
        check("bc0_protocol_err", DW'(protocol_err), DW'(1));
        repeat (10) @(posedge clk); #1;

        check("scoreboard_drained", DW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
